life_tracker: RTL and testbench

- Upstream feeder of game_state. Tracks Mario's lives, hit handling, death animation timing, respawn and post-hit invulnerability.
- Raises initGameOver when the last life is spent, which drives game_state from ON to OFF.
- Consumes per-frame hazard events from the collision, level-timer and power-up logic.
- Counts in frame_tick units; the system clock runs all logic.

---
 rtl/mario_pkg.sv | 21 ++
 rtl/life_tracker_if.sv | 33 +++
 rtl/frame_down_counter.sv | 30 +++
 rtl/life_tracker.sv | 174 +++++++++++++++++
 tb/tb_life_tracker.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mario_pkg.sv
// Shared types and default timing/lives constants for the Mario game blocks.
package mario_pkg;

  // Life-tracking states, 3-bit encoded.
  typedef enum logic [2:0] {
    IDLE,
    ALIVE,
    INVULN,
    DYING,
    HOLD,
    GAMEOVER
  } life_state_t;

  localparam int DEF_START_LIVES   = 3;
  localparam int DEF_MAX_LIVES     = 9;
  localparam int DEF_LIVES_W       = 4;
  localparam int DEF_DEATH_FRAMES  = 120;
  localparam int DEF_INVULN_FRAMES = 90;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/life_tracker_if.sv
// Hazard inputs and life/status outputs exchanged between the game logic
// (master) and the life tracker (slave).
interface life_tracker_if
  import mario_pkg::*;
#(
  parameter int LIVES_W = DEF_LIVES_W
);

  logic               frame_tick;
  logic               game_active;
  logic               enemy_hit;
  logic               pit_fall;
  logic               time_up;
  logic               big_mario;
  logic               extra_life;
  logic [LIVES_W-1:0] lives;
  logic               dying;
  logic               invincible;
  logic               shrink;
  logic               respawn;
  logic               initGameOver;

  modport master (
    output frame_tick, game_active, enemy_hit, pit_fall, time_up, big_mario, extra_life,
    input  lives, dying, invincible, shrink, respawn, initGameOver
  );

  modport slave (
    input  frame_tick, game_active, enemy_hit, pit_fall, time_up, big_mario, extra_life,
    output lives, dying, invincible, shrink, respawn, initGameOver
  );

endinterface

// File: rtl/frame_down_counter.sv
// Loadable frame-tick down counter; stops at zero. Used for the death and
// invulnerability windows, and later for invincibility-star timing.
module frame_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic [CNT_W-1:0] count,
  output logic             at_one
);

  // Load has priority over tick, so a window loaded on a tick edge starts full.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign at_one = (count == CNT_W'(1));

endmodule

// File: rtl/life_tracker.sv
// Tracks Mario's lives, hit handling, death animation, respawn and post-hit
// invulnerability; raises initGameOver when the last life is spent.
module life_tracker
  import mario_pkg::*;
#(
  parameter int START_LIVES   = DEF_START_LIVES,
  parameter int MAX_LIVES     = DEF_MAX_LIVES,
  parameter int LIVES_W       = DEF_LIVES_W,
  parameter int DEATH_FRAMES  = DEF_DEATH_FRAMES,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic           Clk,
  input  logic           Reset,
  life_tracker_if.slave  bus
);

  localparam logic [CNT_W-1:0] DEATH_LOAD  = CNT_W'(DEATH_FRAMES);
  localparam logic [CNT_W-1:0] INVULN_LOAD = CNT_W'(INVULN_FRAMES);

  life_state_t        state;
  logic [LIVES_W-1:0] lives_q;
  logic               dying_q;
  logic               invincible_q;
  logic               shrink_q;
  logic               respawn_q;
  logic               game_over_q;

  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_tick;
  logic [CNT_W-1:0]   cnt_count;
  logic               cnt_at_one;

  logic               env_kill;
  logic               expire;
  logic [LIVES_W-1:0] lives_inc;

  // Falling into a pit or running out of time kills even a powered-up Mario.
  assign env_kill  = bus.pit_fall | bus.time_up;
  // Last frame of a running window.
  assign expire    = bus.frame_tick & cnt_at_one;
  // 1-up saturates at the ceiling.
  assign lives_inc = (lives_q >= LIVES_W'(MAX_LIVES)) ? lives_q : lives_q + LIVES_W'(1);
  // Ticks are only forwarded while a window is running.
  assign cnt_tick  = bus.frame_tick & (cnt_count != '0);

  // Decide when the frame counter is (re)loaded and with what.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      ALIVE: begin
        if (!bus.game_active) begin
          cnt_load = 1'b1;
        end else if (env_kill || (bus.enemy_hit && !bus.big_mario)) begin
          cnt_load = 1'b1;
          cnt_val  = DEATH_LOAD;
        end else if (bus.enemy_hit) begin
          cnt_load = 1'b1;
          cnt_val  = INVULN_LOAD;
        end
      end
      INVULN: begin
        if (!bus.game_active) begin
          cnt_load = 1'b1;
        end else if (env_kill) begin
          cnt_load = 1'b1;
          cnt_val  = DEATH_LOAD;
        end
      end
      DYING: begin
        if (!bus.game_active) cnt_load = 1'b1;
      end
      HOLD:    cnt_load = 1'b1;
      default: ;
    endcase
  end

  frame_down_counter #(
    .CNT_W (CNT_W)
  ) u_frame_cnt (
    .Clk      (Clk),
    .Reset    (Reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tick     (cnt_tick),
    .count    (cnt_count),
    .at_one   (cnt_at_one)
  );

  // Life-state machine with registered outputs; pulses default low each cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      lives_q      <= LIVES_W'(START_LIVES);
      dying_q      <= 1'b0;
      invincible_q <= 1'b0;
      shrink_q     <= 1'b0;
      respawn_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      shrink_q  <= 1'b0;
      respawn_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.game_active) state <= ALIVE;
        end
        ALIVE: begin
          if (!bus.game_active) begin
            state <= HOLD;
          end else if (env_kill || (bus.enemy_hit && !bus.big_mario)) begin
            state   <= DYING;
            dying_q <= 1'b1;
          end else if (bus.enemy_hit) begin
            state        <= INVULN;
            invincible_q <= 1'b1;
            shrink_q     <= 1'b1;
          end else if (bus.extra_life) begin
            lives_q <= lives_inc;
          end
        end
        INVULN: begin
          if (!bus.game_active) begin
            state        <= HOLD;
            invincible_q <= 1'b0;
          end else if (env_kill) begin
            state        <= DYING;
            invincible_q <= 1'b0;
            dying_q      <= 1'b1;
          end else begin
            if (bus.extra_life) lives_q <= lives_inc;
            if (expire) begin
              state        <= ALIVE;
              invincible_q <= 1'b0;
            end
          end
        end
        DYING: begin
          if (!bus.game_active) begin
            state   <= HOLD;
            dying_q <= 1'b0;
          end else if (expire) begin
            dying_q <= 1'b0;
            if (lives_q > LIVES_W'(1)) begin
              state     <= ALIVE;
              lives_q   <= lives_q - LIVES_W'(1);
              respawn_q <= 1'b1;
            end else begin
              state       <= GAMEOVER;
              lives_q     <= '0;
              game_over_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.game_active) state <= ALIVE;
        end
        GAMEOVER: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.lives        = lives_q;
  assign bus.dying        = dying_q;
  assign bus.invincible   = invincible_q;
  assign bus.shrink       = shrink_q;
  assign bus.respawn      = respawn_q;
  assign bus.initGameOver = game_over_q;

endmodule

// File: tb/tb_life_tracker.sv
// Self-checking bench for life_tracker: directed scenarios with literal
// expectations plus a cycle-by-cycle comparison against a behavioural model.
module tb_life_tracker;

  localparam int START_L = 3;
  localparam int MAX_L   = 9;
  localparam int DEATH_F = 120;
  localparam int INV_F   = 90;

  // Model phases: playing covers both normal and invulnerable play.
  localparam int PH_IDLE = 0;
  localparam int PH_PLAY = 1;
  localparam int PH_DEAD = 2;
  localparam int PH_HOLD = 3;
  localparam int PH_OVER = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  life_tracker_if #(.LIVES_W(4)) bus ();

  life_tracker #(
    .START_LIVES   (START_L),
    .MAX_LIVES     (MAX_L),
    .LIVES_W       (4),
    .DEATH_FRAMES  (DEATH_F),
    .INVULN_FRAMES (INV_F),
    .CNT_W         (8)
  ) dut (
    .Clk   (clk),
    .Reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase, m_lives, m_death_left, m_inv_left;
  bit m_shrink, m_respawn;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase      <= PH_IDLE;
      m_lives      <= START_L;
      m_death_left <= 0;
      m_inv_left   <= 0;
      m_shrink     <= 1'b0;
      m_respawn    <= 1'b0;
    end else begin
      m_shrink  <= 1'b0;
      m_respawn <= 1'b0;
      case (m_phase)
        PH_IDLE: if (bus.game_active) m_phase <= PH_PLAY;
        PH_PLAY: begin
          if (!bus.game_active) begin
            m_phase    <= PH_HOLD;
            m_inv_left <= 0;
          end else if (bus.pit_fall || bus.time_up) begin
            m_phase      <= PH_DEAD;
            m_death_left <= DEATH_F;
            m_inv_left   <= 0;
          end else if (bus.enemy_hit && m_inv_left == 0 && bus.big_mario) begin
            m_inv_left <= INV_F;
            m_shrink   <= 1'b1;
          end else if (bus.enemy_hit && m_inv_left == 0) begin
            m_phase      <= PH_DEAD;
            m_death_left <= DEATH_F;
          end else begin
            if (bus.extra_life) m_lives <= (m_lives < MAX_L) ? m_lives + 1 : MAX_L;
            if (bus.frame_tick && m_inv_left > 0) m_inv_left <= m_inv_left - 1;
          end
        end
        PH_DEAD: begin
          if (!bus.game_active) begin
            m_phase      <= PH_HOLD;
            m_death_left <= 0;
          end else if (bus.frame_tick) begin
            m_death_left <= m_death_left - 1;
            if (m_death_left == 1) begin
              if (m_lives > 1) begin
                m_lives   <= m_lives - 1;
                m_respawn <= 1'b1;
                m_phase   <= PH_PLAY;
              end else begin
                m_lives <= 0;
                m_phase <= PH_OVER;
              end
            end
          end
        end
        PH_HOLD: if (bus.game_active) m_phase <= PH_PLAY;
        default: ;
      endcase
    end
  end

  // Compare DUT against the model on every falling edge outside reset.
  always @(negedge clk) begin
    if (!reset) begin
      check("cycle",
            {23'd0, bus.lives, bus.dying, bus.invincible, bus.shrink, bus.respawn, bus.initGameOver},
            {23'd0, m_lives[3:0], (m_phase == PH_DEAD), (m_phase == PH_PLAY && m_inv_left > 0),
             m_shrink, m_respawn, (m_phase == PH_OVER)});
    end
  end

  // Pulse counters sampled away from the active edge.
  int respawn_cnt = 0;
  int shrink_cnt  = 0;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.respawn) respawn_cnt++;
      if (bus.shrink)  shrink_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  int inv_ticks   = 0;
  int dying_ticks = 0;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.frame_tick = 1'b1;
      if (bus.invincible) inv_ticks++;
      if (bus.dying) dying_ticks++;
      @(negedge clk);
      bus.frame_tick = 1'b0;
    end
  endtask

  task automatic pulse_enemy();
    @(negedge clk) bus.enemy_hit = 1'b1;
    @(negedge clk) bus.enemy_hit = 1'b0;
  endtask

  task automatic pulse_extra();
    @(negedge clk) bus.extra_life = 1'b1;
    @(negedge clk) bus.extra_life = 1'b0;
  endtask

  task automatic clear_inputs();
    bus.frame_tick  = 1'b0;
    bus.game_active = 1'b0;
    bus.enemy_hit   = 1'b0;
    bus.pit_fall    = 1'b0;
    bus.time_up     = 1'b0;
    bus.big_mario   = 1'b0;
    bus.extra_life  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    idle(2);
    reset = 1'b0;
    bus.game_active = 1'b1;
    idle(2);
  endtask

  // Watchdog: the sequence is bounded, this only guards against a stuck run.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int r0, s0, go_cycles;

  initial begin
    clear_inputs();
    idle(3);
    check("reset_lives", bus.lives, START_L);
    check("reset_flags", {bus.dying, bus.invincible, bus.shrink, bus.respawn, bus.initGameOver}, 0);
    reset = 1'b0;
    bus.game_active = 1'b1;
    idle(2);

    // Small Mario hit: full death animation then respawn.
    r0 = respawn_cnt;
    dying_ticks = 0;
    pulse_enemy();
    check("t1_dying_on", bus.dying, 1);
    ticks(DEATH_F - 1);
    check("t1_still_dying", bus.dying, 1);
    check("t1_lives_held", bus.lives, 3);
    ticks(1);
    idle(1);
    check("t1_dying_ticks", dying_ticks, DEATH_F);
    check("t1_respawn_cnt", respawn_cnt - r0, 1);
    check("t1_lives", bus.lives, 2);
    check("t1_alive", {bus.dying, bus.invincible}, 0);

    // Big Mario hit held for ~50 frames; hit coincides with a frame tick.
    do_reset();
    bus.big_mario = 1'b1;
    s0 = shrink_cnt;
    inv_ticks = 0;
    dying_ticks = 0;
    @(negedge clk);
    bus.enemy_hit  = 1'b1;
    bus.frame_tick = 1'b1;
    @(negedge clk);
    bus.frame_tick = 1'b0;
    check("t2_inv_on", bus.invincible, 1);
    ticks(49);
    bus.enemy_hit = 1'b0;
    ticks(51);
    idle(1);
    check("t2_inv_ticks", inv_ticks, INV_F);
    check("t2_shrink_cnt", shrink_cnt - s0, 1);
    check("t2_lives", bus.lives, 3);
    check("t2_no_dying", dying_ticks, 0);
    check("t2_inv_off", bus.invincible, 0);

    // Extra life accepted while invulnerable, then pit fall kills.
    do_reset();
    bus.big_mario = 1'b1;
    pulse_enemy();
    check("t3_inv_on", bus.invincible, 1);
    ticks(10);
    pulse_extra();
    check("t3_lives_up", bus.lives, 4);
    @(negedge clk) bus.pit_fall = 1'b1;
    @(negedge clk) bus.pit_fall = 1'b0;
    check("t3_inv_dropped", bus.invincible, 0);
    check("t3_dying", bus.dying, 1);
    ticks(DEATH_F);
    idle(1);
    check("t3_lives", bus.lives, 3);
    bus.big_mario = 1'b0;

    // Three small deaths: game over with no third respawn.
    do_reset();
    r0 = respawn_cnt;
    for (int k = 0; k < 3; k++) begin
      pulse_enemy();
      ticks(DEATH_F);
      idle(1);
      check("t4_lives_step", bus.lives, 2 - k);
    end
    check("t4_respawn_cnt", respawn_cnt - r0, 2);
    check("t4_gameover", bus.initGameOver, 1);
    go_cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (bus.initGameOver) go_cycles++;
      bus.extra_life  = (i == 10);
      bus.enemy_hit   = (i == 20);
      bus.game_active = !(i >= 500 && i < 600);
    end
    bus.extra_life = 1'b0;
    bus.enemy_hit  = 1'b0;
    idle(1);
    check("t4_go_sticky", go_cycles, 1000);
    check("t4_lives_zero", bus.lives, 0);

    // Extra lives saturate at the ceiling.
    do_reset();
    repeat (6) pulse_extra();
    check("t5_lives_max", bus.lives, MAX_L);
    pulse_extra();
    check("t5_lives_sat", bus.lives, MAX_L);

    // 1-up coinciding with a small hit is dropped.
    do_reset();
    @(negedge clk);
    bus.enemy_hit  = 1'b1;
    bus.extra_life = 1'b1;
    @(negedge clk);
    bus.enemy_hit  = 1'b0;
    bus.extra_life = 1'b0;
    check("t5_coinc_dying", bus.dying, 1);
    check("t5_coinc_lives", bus.lives, 3);

    // Leaving play mid-death cancels it.
    ticks(60);
    @(negedge clk) bus.game_active = 1'b0;
    @(negedge clk);
    check("t6_hold_dying", bus.dying, 0);
    check("t6_hold_lives", bus.lives, 3);
    bus.game_active = 1'b1;
    idle(3);

    // Time-up death, then asynchronous reset mid-animation.
    @(negedge clk) bus.time_up = 1'b1;
    @(negedge clk) bus.time_up = 1'b0;
    check("t6_timeup_dying", bus.dying, 1);
    ticks(30);
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_lives", bus.lives, START_L);
    check("t6_async_flags", {bus.dying, bus.invincible, bus.shrink, bus.respawn, bus.initGameOver}, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(3);
    check("t6_after_reset", {bus.dying, bus.invincible}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
